noc_packetizer: RTL and testbench
=================================

NOC_PACKETIZER -- requirements
Module: noc_packetizer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32, meaning payload word and flit data width.
REQ-002 The module SHALL have parameter XY_W, default 4, meaning mesh coordinate width.
REQ-003 The module SHALL have parameter MAX_LEN, default 8, meaning maximum payload words per packet; LEN_W = $clog2(MAX_LEN+1).
REQ-004 The module SHALL have parameter CREDITS, default 4, meaning depth of the router local-port input buffer.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The module SHALL have port rst, input, 1 bit: the reset, synchronous and active-high.
REQ-007 The module SHALL have ports my_xpos and my_ypos, input, XY_W bits each: the source node coordinates.
REQ-008 The module SHALL have ports msg_valid (input, 1), msg_ready (output, 1), msg_dst_x (input, XY_W), msg_dst_y (input, XY_W) and msg_len (input, LEN_W): the message descriptor handshake.
REQ-009 The module SHALL have ports pld_valid (input, 1), pld_ready (output, 1) and pld_data (input, DATA_W): the payload word stream.
REQ-010 The module SHALL have ports flit_valid (output, 1), flit_type (output, 2) and flit_data (output, DATA_W): flits to the router local input port.
REQ-011 The module SHALL have port credit_in, input, 1 bit: one pulse per freed router buffer slot.
REQ-012 The module SHALL have port err_credit, output, 1 bit: sticky credit-overflow flag.

Function
REQ-013 The block SHALL be the network interface upstream of the router local input port, converting descriptor plus payload into head/body/tail flits.
REQ-014 The flit_type encoding SHALL be: BODY=2'b00, HEAD=2'b01, TAIL=2'b10, HEADTAIL=2'b11.
REQ-015 The head flit_data SHALL be {dst_x, dst_y, src_x, src_y, len}, LSB-aligned, with the upper bits zero.
REQ-016 The FSM SHALL have three states, IDLE, HEAD and BODY.
REQ-017 In IDLE, msg_ready SHALL be 1; on msg_valid&&msg_ready the block SHALL latch dst, len and my_xpos/my_ypos and go to HEAD on the next cycle.
REQ-018 In HEAD, flit_valid SHALL be (crd_cnt>0).
REQ-019 When the head flit issues with len==0, its type SHALL be HEADTAIL and the next state SHALL be IDLE.
REQ-020 When the head flit issues with len>0, its type SHALL be HEAD and the next state SHALL be BODY.
REQ-021 In BODY, pld_ready SHALL be (crd_cnt>0), flit_valid SHALL be pld_valid&&(crd_cnt>0), and flit_data SHALL be pld_data (combinational pass-through).
REQ-022 The body flit whose index equals len-1 SHALL have type TAIL, after which the state SHALL return to IDLE; all other body flits SHALL have type BODY.
REQ-023 A flit SHALL be considered issued on every cycle with flit_valid=1; there is no ready from the router.
REQ-024 In any state other than the one that drives it, msg_ready, pld_ready and flit_valid SHALL be 0.
REQ-025 msg_len values greater than MAX_LEN SHALL be clamped to MAX_LEN.
REQ-026 The credit counter crd_cnt, of width $clog2(CREDITS+1), SHALL decrement by one per issued flit and increment by one per credit_in pulse.
REQ-027 A simultaneous flit issue and credit_in SHALL leave crd_cnt unchanged.
REQ-028 credit_in arriving with crd_cnt==CREDITS and no issue in that cycle SHALL hold crd_cnt at CREDITS and set err_credit.
REQ-029 A credit_in pulse SHALL make a flit issuable on the next cycle; the minimum latency from msg accept to the head flit is 1 cycle.
REQ-030 At crd_cnt==0 the block SHALL stall with flit_valid=0 and pld_ready=0 and no state change.

Reset
REQ-031 On rst=1 at a clock edge, the block SHALL set state=IDLE, crd_cnt=CREDITS, the body index to 0, err_credit=0 and the latched descriptor to 0.
REQ-032 While rst=1, the outputs SHALL be msg_ready=0, pld_ready=0, flit_valid=0, flit_type=0 and flit_data=0.
REQ-033 A reset asserted mid-packet SHALL abandon the packet without emitting a tail flit; credit state SHALL restart at CREDITS.

Structure
REQ-034 The flit_type enum, the head-flit field layout and the default widths SHALL reside in noc_pkg.
REQ-035 The credit counter SHALL be a separate sub-module, noc_credit_cnt (parameter CREDITS; ports clk, rst, dec, inc, cnt, avail, err).

Verification
REQ-036 The bench SHALL cover: after reset, msg dst=(2,3), len=3, src=(1,1), payload A0,A1,A2, credits ample -> flits HEAD{2,3,1,1,3}, BODY A0, BODY A1, TAIL A2 on consecutive cycles starting 1 cycle after accept.
REQ-037 The bench SHALL cover: len=0 -> a single HEADTAIL flit, then msg_ready=1 on the next cycle.
REQ-038 The bench SHALL cover: CREDITS=4, no credit_in, len=6 -> exactly 4 flits issued then a stall; one credit_in pulse -> exactly 1 more flit on the next cycle.
REQ-039 The bench SHALL cover: credit_in in the same cycle as an issue at crd_cnt=1 -> crd_cnt stays 1 and the next flit issues.
REQ-040 The bench SHALL cover: credit_in at crd_cnt=4 while idle -> err_credit=1 and sticky, crd_cnt=4.
REQ-041 The bench SHALL cover: rst asserted after the 2nd body flit of len=5 -> the next cycle is IDLE, crd_cnt=4, no TAIL emitted, and the next packet is formed correctly.

Source files
------------

// File: rtl/noc_pkg.sv
// noc_pkg: shared flit encodings, head-flit layout and default widths for the NoC interface
package noc_pkg;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_XY_W    = 4;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CREDITS = 4;
  typedef enum logic [1:0] {
    FT_BODY     = 2'b00,
    FT_HEAD     = 2'b01,
    FT_TAIL     = 2'b10,
    FT_HEADTAIL = 2'b11
  } flit_type_e;
  // Head flit packs {dst_x, dst_y, src_x, src_y, len} MSB to LSB, LSB-aligned, upper bits zero.
  function automatic int head_w(input int xy_w, input int len_w);
    return 4 * xy_w + len_w;
  endfunction
endpackage

// File: rtl/noc_credit_cnt.sv
// noc_credit_cnt: free-slot counter for the router local input buffer with sticky overflow flag
module noc_credit_cnt import noc_pkg::*; #(
  parameter  int CREDITS = DEF_CREDITS,
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dec,
  input  logic          inc,
  output logic [CW-1:0] cnt,
  output logic          avail,
  output logic          err
);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  // An issue consumes a slot, a credit returns one; both together cancel; a credit with no room is an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= CW'(CREDITS);
      r_err <= 1'b0;
    end else if (inc && !dec) begin
      if (r_cnt == CW'(CREDITS)) r_err <= 1'b1;
      else r_cnt <= r_cnt + CW'(1);
    end else if (dec && !inc) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end
  assign cnt   = r_cnt;
  assign avail = |r_cnt;
  assign err   = r_err;
endmodule

// File: rtl/noc_packetizer.sv
// noc_packetizer: network interface turning a descriptor plus payload into head/body/tail flits under credit flow control
module noc_packetizer import noc_pkg::*; #(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int XY_W    = DEF_XY_W,
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int CREDITS = DEF_CREDITS,
  localparam int LEN_W   = $clog2(MAX_LEN + 1),
  localparam int CRD_W   = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XY_W-1:0]   my_xpos,
  input  logic [XY_W-1:0]   my_ypos,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [XY_W-1:0]   msg_dst_x,
  input  logic [XY_W-1:0]   msg_dst_y,
  input  logic [LEN_W-1:0]  msg_len,
  input  logic              pld_valid,
  output logic              pld_ready,
  input  logic [DATA_W-1:0] pld_data,
  output logic              flit_valid,
  output logic [1:0]        flit_type,
  output logic [DATA_W-1:0] flit_data,
  input  logic              credit_in,
  output logic              err_credit
);
  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY} state_e;
  localparam int HEAD_W = head_w(XY_W, LEN_W);
  state_e            r_state, w_state_nxt;
  logic [XY_W-1:0]   r_dst_x, r_dst_y, r_src_x, r_src_y;
  logic [LEN_W-1:0]  r_len, r_idx, w_len_in;
  logic [HEAD_W-1:0] w_head;
  logic [CRD_W-1:0]  w_crd_cnt;
  logic              w_avail, w_issue, w_last, w_accept;
  assign w_len_in = (msg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : msg_len;
  assign w_head   = {r_dst_x, r_dst_y, r_src_x, r_src_y, r_len};
  assign w_last   = r_idx == r_len - LEN_W'(1);
  assign w_accept = r_state == S_IDLE && msg_valid;
  assign w_issue  = w_avail && (r_state == S_HEAD || (r_state == S_BODY && pld_valid));
  noc_credit_cnt #(.CREDITS(CREDITS)) u_crd (
    .clk  (clk),
    .rst  (rst),
    .dec  (w_issue),
    .inc  (credit_in),
    .cnt  (w_crd_cnt),
    .avail(w_avail),
    .err  (err_credit)
  );
  // Next state and handshake/flit outputs; all outputs held low while reset is asserted.
  always_comb begin
    w_state_nxt = r_state;
    msg_ready   = 1'b0;
    pld_ready   = 1'b0;
    flit_valid  = 1'b0;
    flit_type   = FT_BODY;
    flit_data   = '0;
    if (!rst) begin
      unique case (r_state)
        S_IDLE: begin
          msg_ready   = 1'b1;
          w_state_nxt = msg_valid ? S_HEAD : S_IDLE;
        end
        S_HEAD: begin
          flit_valid  = w_avail;
          flit_type   = (r_len == '0) ? FT_HEADTAIL : FT_HEAD;
          flit_data   = DATA_W'(w_head);
          w_state_nxt = !w_avail ? S_HEAD : (r_len == '0) ? S_IDLE : S_BODY;
        end
        S_BODY: begin
          pld_ready   = w_avail;
          flit_valid  = w_issue;
          flit_type   = w_last ? FT_TAIL : FT_BODY;
          flit_data   = pld_data;
          w_state_nxt = (w_issue && w_last) ? S_IDLE : S_BODY;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end
  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else r_state <= w_state_nxt;
  end
  // Latch the descriptor and source on accept; count body flits issued in the current packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dst_x <= '0;
      r_dst_y <= '0;
      r_src_x <= '0;
      r_src_y <= '0;
      r_len   <= '0;
      r_idx   <= '0;
    end else begin
      if (w_accept) begin
        r_dst_x <= msg_dst_x;
        r_dst_y <= msg_dst_y;
        r_src_x <= my_xpos;
        r_src_y <= my_ypos;
        r_len   <= w_len_in;
      end
      if (r_state == S_HEAD) r_idx <= '0;
      else if (r_state == S_BODY && w_issue) r_idx <= r_idx + LEN_W'(1);
    end
  end
  // The credit count can never exceed the router buffer depth.
  assert property (@(posedge clk) disable iff (rst) w_crd_cnt <= CRD_W'(CREDITS));
endmodule

// File: tb/tb_noc_packetizer.sv
// tb_noc_packetizer: directed self-checking bench for noc_packetizer
module tb_noc_packetizer;
  logic        clk = 1'b0, rst = 1'b1;
  logic [3:0]  my_xpos = '0, my_ypos = '0, msg_dst_x = '0, msg_dst_y = '0, msg_len = '0;
  logic        msg_valid = 1'b0, pld_valid = 1'b0, credit_in = 1'b0;
  logic [31:0] pld_data = '0;
  logic        msg_ready, pld_ready, flit_valid, err_credit;
  logic [1:0]  flit_type;
  logic [31:0] flit_data;
  int n_pass = 0, n_total = 0;

  noc_packetizer dut (
    .clk(clk), .rst(rst), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_dst_x(msg_dst_x), .msg_dst_y(msg_dst_y), .msg_len(msg_len),
    .pld_valid(pld_valid), .pld_ready(pld_ready), .pld_data(pld_data),
    .flit_valid(flit_valid), .flit_type(flit_type), .flit_data(flit_data),
    .credit_in(credit_in), .err_credit(err_credit)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic give_credits(input int n);
    credit_in = 1'b1;
    repeat (n) tick();
    credit_in = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    msg_valid = 1'b1; pld_valid = 1'b1; pld_data = 32'hFFFF_FFFF; msg_len = 4'd3;
    @(negedge clk);
    n_total++; if (msg_ready !== 1'b0) $display("FAIL rst_msg_ready got %b want 0", msg_ready); else n_pass++;
    n_total++; if (pld_ready !== 1'b0) $display("FAIL rst_pld_ready got %b want 0", pld_ready); else n_pass++;
    n_total++; if (flit_valid !== 1'b0) $display("FAIL rst_flit_valid got %b want 0", flit_valid); else n_pass++;
    n_total++; if (flit_type !== 2'b00) $display("FAIL rst_flit_type got %b want 00", flit_type); else n_pass++;
    n_total++; if (flit_data !== 32'h0) $display("FAIL rst_flit_data got %h want 0", flit_data); else n_pass++;
    tick();
    rst = 1'b0; msg_valid = 1'b0; pld_valid = 1'b0; msg_len = '0; pld_data = '0;
    @(negedge clk);
    n_total++; if (msg_ready !== 1'b1) $display("FAIL post_rst_msg_ready got %b want 1", msg_ready); else n_pass++;
    n_total++; if (dut.w_crd_cnt !== 3'd4) $display("FAIL post_rst_crd got %0d want 4", dut.w_crd_cnt); else n_pass++;
    n_total++; if (err_credit !== 1'b0) $display("FAIL post_rst_err got %b want 0", err_credit); else n_pass++;
    n_total++; if (flit_valid !== 1'b0) $display("FAIL post_rst_flit_valid got %b want 0", flit_valid); else n_pass++;
  endtask

  task automatic test_basic();
    logic [31:0] pl [3] = '{32'hA000_0000, 32'hA100_0001, 32'hA200_0002};
    logic [1:0]  ft [3] = '{2'b00, 2'b00, 2'b10};
    tick();
    my_xpos = 4'd1; my_ypos = 4'd1;
    msg_valid = 1'b1; msg_dst_x = 4'd2; msg_dst_y = 4'd3; msg_len = 4'd3;
    @(negedge clk);
    n_total++; if (msg_ready !== 1'b1) $display("FAIL basic_accept_ready got %b want 1", msg_ready); else n_pass++;
    tick();
    msg_valid = 1'b0; msg_len = '0;
    @(negedge clk);
    n_total++; if (flit_valid !== 1'b1) $display("FAIL basic_head_valid got %b want 1", flit_valid); else n_pass++;
    n_total++; if (flit_type !== 2'b01) $display("FAIL basic_head_type got %b want 01", flit_type); else n_pass++;
    n_total++; if (flit_data !== 32'h0002_3113) $display("FAIL basic_head_data got %h want 00023113", flit_data); else n_pass++;
    n_total++; if (msg_ready !== 1'b0) $display("FAIL basic_head_msg_ready got %b want 0", msg_ready); else n_pass++;
    tick();
    pld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pld_data = pl[i];
      @(negedge clk);
      n_total++; if (flit_valid !== 1'b1) $display("FAIL basic_body%0d_valid got %b want 1", i, flit_valid); else n_pass++;
      n_total++; if (flit_type !== ft[i]) $display("FAIL basic_body%0d_type got %b want %b", i, flit_type, ft[i]); else n_pass++;
      n_total++; if (flit_data !== pl[i]) $display("FAIL basic_body%0d_data got %h want %h", i, flit_data, pl[i]); else n_pass++;
      n_total++; if (pld_ready !== 1'b1) $display("FAIL basic_body%0d_pld_ready got %b want 1", i, pld_ready); else n_pass++;
      tick();
    end
    pld_valid = 1'b0;
    @(negedge clk);
    n_total++; if (msg_ready !== 1'b1) $display("FAIL basic_done_msg_ready got %b want 1", msg_ready); else n_pass++;
    n_total++; if (flit_valid !== 1'b0) $display("FAIL basic_done_flit_valid got %b want 0", flit_valid); else n_pass++;
    n_total++; if (dut.w_crd_cnt !== 3'd0) $display("FAIL basic_done_crd got %0d want 0", dut.w_crd_cnt); else n_pass++;
    give_credits(4);
  endtask

  task automatic test_headtail();
    msg_valid = 1'b1; msg_dst_x = 4'd5; msg_dst_y = 4'd6; msg_len = 4'd0;
    tick();
    msg_valid = 1'b0;
    @(negedge clk);
    n_total++; if (flit_valid !== 1'b1) $display("FAIL ht_valid got %b want 1", flit_valid); else n_pass++;
    n_total++; if (flit_type !== 2'b11) $display("FAIL ht_type got %b want 11", flit_type); else n_pass++;
    n_total++; if (flit_data !== 32'h0005_6110) $display("FAIL ht_data got %h want 00056110", flit_data); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (msg_ready !== 1'b1) $display("FAIL ht_next_msg_ready got %b want 1", msg_ready); else n_pass++;
    n_total++; if (flit_valid !== 1'b0) $display("FAIL ht_next_flit_valid got %b want 0", flit_valid); else n_pass++;
    n_total++; if (dut.w_crd_cnt !== 3'd3) $display("FAIL ht_crd got %0d want 3", dut.w_crd_cnt); else n_pass++;
    give_credits(1);
  endtask

  task automatic test_stall();
    int n = 0;
    msg_valid = 1'b1; msg_dst_x = 4'd7; msg_dst_y = 4'd0; msg_len = 4'd6;
    pld_valid = 1'b1; pld_data = 32'hB000_0000;
    tick();
    msg_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (flit_valid) n++;
      tick();
      pld_data = pld_data + 32'd1;
    end
    @(negedge clk);
    n_total++; if (n !== 4) $display("FAIL stall_flit_count got %0d want 4", n); else n_pass++;
    n_total++; if (flit_valid !== 1'b0) $display("FAIL stall_flit_valid got %b want 0", flit_valid); else n_pass++;
    n_total++; if (pld_ready !== 1'b0) $display("FAIL stall_pld_ready got %b want 0", pld_ready); else n_pass++;
    n_total++; if (msg_ready !== 1'b0) $display("FAIL stall_msg_ready got %b want 0", msg_ready); else n_pass++;
    n_total++; if (dut.w_crd_cnt !== 3'd0) $display("FAIL stall_crd got %0d want 0", dut.w_crd_cnt); else n_pass++;
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0; pld_data = 32'hB000_0033;
    @(negedge clk);
    n_total++; if (flit_valid !== 1'b1) $display("FAIL stall_resume_valid got %b want 1", flit_valid); else n_pass++;
    n_total++; if (flit_type !== 2'b00) $display("FAIL stall_resume_type got %b want 00", flit_type); else n_pass++;
    n_total++; if (flit_data !== 32'hB000_0033) $display("FAIL stall_resume_data got %h want b0000033", flit_data); else n_pass++;
    tick();
    @(negedge clk);
    n_total++; if (flit_valid !== 1'b0) $display("FAIL stall_again_valid got %b want 0", flit_valid); else n_pass++;
  endtask

  task automatic test_same_cycle();
    credit_in = 1'b1;
    tick();
    @(negedge clk);
    n_total++; if (flit_valid !== 1'b1) $display("FAIL same_issue_valid got %b want 1", flit_valid); else n_pass++;
    n_total++; if (flit_type !== 2'b00) $display("FAIL same_issue_type got %b want 00", flit_type); else n_pass++;
    n_total++; if (dut.w_crd_cnt !== 3'd1) $display("FAIL same_before_crd got %0d want 1", dut.w_crd_cnt); else n_pass++;
    tick();
    credit_in = 1'b0;
    @(negedge clk);
    n_total++; if (dut.w_crd_cnt !== 3'd1) $display("FAIL same_after_crd got %0d want 1", dut.w_crd_cnt); else n_pass++;
    n_total++; if (flit_valid !== 1'b1) $display("FAIL same_next_valid got %b want 1", flit_valid); else n_pass++;
    n_total++; if (flit_type !== 2'b10) $display("FAIL same_next_type got %b want 10", flit_type); else n_pass++;
    tick();
    pld_valid = 1'b0;
    @(negedge clk);
    n_total++; if (dut.w_crd_cnt !== 3'd0) $display("FAIL same_end_crd got %0d want 0", dut.w_crd_cnt); else n_pass++;
    n_total++; if (msg_ready !== 1'b1) $display("FAIL same_end_msg_ready got %b want 1", msg_ready); else n_pass++;
    give_credits(4);
  endtask

  task automatic test_overflow();
    n_total++; if (err_credit !== 1'b0) $display("FAIL ovf_pre_err got %b want 0", err_credit); else n_pass++;
    credit_in = 1'b1;
    tick();
    credit_in = 1'b0;
    @(negedge clk);
    n_total++; if (err_credit !== 1'b1) $display("FAIL ovf_err got %b want 1", err_credit); else n_pass++;
    n_total++; if (dut.w_crd_cnt !== 3'd4) $display("FAIL ovf_crd got %0d want 4", dut.w_crd_cnt); else n_pass++;
    repeat (3) tick();
    @(negedge clk);
    n_total++; if (err_credit !== 1'b1) $display("FAIL ovf_sticky got %b want 1", err_credit); else n_pass++;
    n_total++; if (dut.w_crd_cnt !== 3'd4) $display("FAIL ovf_sticky_crd got %0d want 4", dut.w_crd_cnt); else n_pass++;
    tick();
  endtask

  task automatic test_clamp();
    int  nb = 0;
    logic done = 1'b0;
    msg_valid = 1'b1; msg_dst_x = 4'd1; msg_dst_y = 4'd2; msg_len = 4'd12;
    tick();
    msg_valid = 1'b0;
    @(negedge clk);
    n_total++; if (flit_type !== 2'b01) $display("FAIL clamp_head_type got %b want 01", flit_type); else n_pass++;
    n_total++; if (flit_data !== 32'h0001_2118) $display("FAIL clamp_head_data got %h want 00012118", flit_data); else n_pass++;
    credit_in = 1'b1; pld_valid = 1'b1; pld_data = 32'hC1A0_0000;
    tick();
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (flit_valid) begin
        nb++;
        if (flit_type == 2'b10) done = 1'b1;
      end
      tick();
    end
    credit_in = 1'b0; pld_valid = 1'b0;
    @(negedge clk);
    n_total++; if (done !== 1'b1) $display("FAIL clamp_tail_seen got %b want 1", done); else n_pass++;
    n_total++; if (nb !== 8) $display("FAIL clamp_body_count got %0d want 8", nb); else n_pass++;
    n_total++; if (dut.w_crd_cnt !== 3'd4) $display("FAIL clamp_crd got %0d want 4", dut.w_crd_cnt); else n_pass++;
    n_total++; if (msg_ready !== 1'b1) $display("FAIL clamp_msg_ready got %b want 1", msg_ready); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    msg_valid = 1'b1; msg_dst_x = 4'd3; msg_dst_y = 4'd4; msg_len = 4'd5;
    pld_valid = 1'b1; pld_data = 32'hC000_0000;
    tick();
    msg_valid = 1'b0;
    @(negedge clk);
    n_total++; if (flit_type !== 2'b01) $display("FAIL mid_head_type got %b want 01", flit_type); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      n_total++; if (flit_valid !== 1'b1 || flit_type !== 2'b00) $display("FAIL mid_body%0d got v=%b t=%b want v=1 t=00", i, flit_valid, flit_type); else n_pass++;
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_total++; if (flit_valid !== 1'b0) $display("FAIL mid_rst_flit_valid got %b want 0", flit_valid); else n_pass++;
    n_total++; if (flit_type !== 2'b00) $display("FAIL mid_rst_flit_type got %b want 00", flit_type); else n_pass++;
    n_total++; if (pld_ready !== 1'b0) $display("FAIL mid_rst_pld_ready got %b want 0", pld_ready); else n_pass++;
    tick();
    rst = 1'b0; pld_valid = 1'b0;
    @(negedge clk);
    n_total++; if (msg_ready !== 1'b1) $display("FAIL mid_idle_msg_ready got %b want 1", msg_ready); else n_pass++;
    n_total++; if (flit_valid !== 1'b0) $display("FAIL mid_no_tail got %b want 0", flit_valid); else n_pass++;
    n_total++; if (dut.w_crd_cnt !== 3'd4) $display("FAIL mid_crd got %0d want 4", dut.w_crd_cnt); else n_pass++;
    n_total++; if (err_credit !== 1'b0) $display("FAIL mid_err got %b want 0", err_credit); else n_pass++;
    tick();
    msg_valid = 1'b1; msg_dst_x = 4'd9; msg_dst_y = 4'd10; msg_len = 4'd1;
    tick();
    msg_valid = 1'b0;
    @(negedge clk);
    n_total++; if (flit_type !== 2'b01) $display("FAIL mid_new_head_type got %b want 01", flit_type); else n_pass++;
    n_total++; if (flit_data !== 32'h0009_A111) $display("FAIL mid_new_head_data got %h want 0009a111", flit_data); else n_pass++;
    tick();
    pld_valid = 1'b1; pld_data = 32'hD00D_0001;
    @(negedge clk);
    n_total++; if (flit_valid !== 1'b1) $display("FAIL mid_new_tail_valid got %b want 1", flit_valid); else n_pass++;
    n_total++; if (flit_type !== 2'b10) $display("FAIL mid_new_tail_type got %b want 10", flit_type); else n_pass++;
    n_total++; if (flit_data !== 32'hD00D_0001) $display("FAIL mid_new_tail_data got %h want d00d0001", flit_data); else n_pass++;
    tick();
    pld_valid = 1'b0;
    @(negedge clk);
    n_total++; if (msg_ready !== 1'b1) $display("FAIL mid_new_done_msg_ready got %b want 1", msg_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_headtail();
    test_stall();
    test_same_cycle();
    test_overflow();
    test_clamp();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
